// File: rtl/cache_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter_pkg
// Shared definitions for the i_cache / d_cache memory-port arbiter:
//   arb_state_e  - arbiter FSM states; the encoding doubles as the owner code
//   OWNER_*      - owner codes presented on the debug/perf 'owner' output
//   SIZE_WORD    - access size used for every instruction fetch
//   SEL_ALL      - byte strobes used for every instruction fetch
//   mem_req_t    - the request fields held on the memory port during a grant
// ---------------------------------------------------------------------------
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_GNT_I = 2'b01,
        ARB_GNT_D = 2'b10
    } arb_state_e;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_INST = 2'b01;
    localparam logic [1:0] OWNER_DATA = 2'b10;

    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [3:0] SEL_ALL   = 4'b1111;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [1:0]  size;
        logic [3:0]  sel;
        logic [31:0] stData;
    } mem_req_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
// Arbitrates i_cache fetches and d_cache loads/stores onto the single memory
// port of axi_interface. The winner's request fields are latched on the grant
// edge and held until mem_ready; the completion pulse goes to the owner only.
// Data requests win, except that after D_MAX_CONSEC consecutive data grants
// with an instruction fetch waiting, the fetch is granted.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   i_a, i_strobe               i_cache request
//   i_ready, i_dout             i_cache completion pulse / read data
//   d_a, d_strobe, d_rw,        d_cache request (address, strobe, write flag,
//   d_size, d_sel, d_din          size, byte strobes, store data)
//   d_ready, d_dout             d_cache completion pulse / read data
//   mem_a, mem_access,          latched request towards axi_interface
//   mem_write, mem_size,
//   mem_sel, mem_st_data
//   mem_ready, mem_data         axi_interface completion / read data
//   owner                       current grant holder (00 none, 01 I, 10 D)
// ---------------------------------------------------------------------------
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int D_MAX_CONSEC = 4,
    parameter int CNT_W        = $clog2(D_MAX_CONSEC + 1)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] i_a,
    input  logic        i_strobe,
    output logic        i_ready,
    output logic [31:0] i_dout,
    input  logic [31:0] d_a,
    input  logic        d_strobe,
    input  logic        d_rw,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_din,
    output logic        d_ready,
    output logic [31:0] d_dout,
    output logic [31:0] mem_a,
    output logic        mem_access,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_st_data,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    output logic [1:0]  owner
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(D_MAX_CONSEC);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] dCnt_q, dCnt_d;
    mem_req_t         req_q, req_d;
    logic             arbitrate;

    // Next-state logic. A new winner is chosen whenever the port is free:
    // either idle, or in the completion cycle of the current grant, which
    // lets back-to-back grants proceed without an idle bubble. The waiting
    // fetch only overrides data priority once the data side has used up its
    // run of D_MAX_CONSEC consecutive grants.
    always_comb begin
        state_d   = state_q;
        dCnt_d    = dCnt_q;
        req_d     = req_q;
        arbitrate = (state_q == ARB_IDLE) || mem_ready;

        if (arbitrate) begin
            state_d = ARB_IDLE;
            if (d_strobe && !(i_strobe && (dCnt_q == CNT_MAX))) begin
                state_d      = ARB_GNT_D;
                req_d.addr   = d_a;
                req_d.write  = d_rw;
                req_d.size   = d_size;
                req_d.sel    = d_sel;
                req_d.stData = d_din;
                if (!i_strobe) begin
                    dCnt_d = '0;
                end else if (dCnt_q != CNT_MAX) begin
                    dCnt_d = dCnt_q + CNT_W'(1);
                end
            end else if (i_strobe) begin
                state_d      = ARB_GNT_I;
                req_d.addr   = i_a;
                req_d.write  = 1'b0;
                req_d.size   = SIZE_WORD;
                req_d.sel    = SEL_ALL;
                req_d.stData = '0;
                dCnt_d       = '0;
            end
        end
    end

    // State, starvation counter and held request fields. Reset drops any
    // in-flight grant at once; axi_interface shares resetn, so nothing needs
    // to be remembered about an interrupted beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
            dCnt_q  <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            dCnt_q  <= dCnt_d;
            req_q   <= req_d;
        end
    end

    // Owner code for the debug/perf port, derived directly from the state.
    always_comb begin
        owner = OWNER_NONE;
        case (state_q)
            ARB_GNT_I: owner = OWNER_INST;
            ARB_GNT_D: owner = OWNER_DATA;
            default:   owner = OWNER_NONE;
        endcase
    end

    // mem_access follows the state so it stays high through the mem_ready
    // cycle; ready pulses are gated by ownership so a stray mem_ready while
    // idle produces nothing.
    assign mem_access  = (state_q != ARB_IDLE);
    assign mem_a       = req_q.addr;
    assign mem_write   = req_q.write;
    assign mem_size    = req_q.size;
    assign mem_sel     = req_q.sel;
    assign mem_st_data = req_q.stData;

    assign i_ready = (state_q == ARB_GNT_I) && mem_ready;
    assign d_ready = (state_q == ARB_GNT_D) && mem_ready;
    assign i_dout  = mem_data;
    assign d_dout  = mem_data;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_arbiter
// Self-checking bench for cache_mem_arbiter: directed scenarios for reset,
// lone fetch, lone store, simultaneous requests, starvation guard, reset in
// the middle of a grant and stray mem_ready, followed by a randomized run
// checked against a cycle-level reference model of the arbitration rules.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_cache_mem_arbiter;

    localparam int DMAX = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] i_a;
    logic        i_strobe;
    logic        i_ready;
    logic [31:0] i_dout;
    logic [31:0] d_a;
    logic        d_strobe;
    logic        d_rw;
    logic [1:0]  d_size;
    logic [3:0]  d_sel;
    logic [31:0] d_din;
    logic        d_ready;
    logic [31:0] d_dout;
    logic [31:0] mem_a;
    logic        mem_access;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [3:0]  mem_sel;
    logic [31:0] mem_st_data;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic [1:0]  owner;

    int nCompared   = 0;
    int nMismatched = 0;

    cache_mem_arbiter #(.D_MAX_CONSEC(DMAX)) dut (
        .clk(clk), .resetn(resetn),
        .i_a(i_a), .i_strobe(i_strobe), .i_ready(i_ready), .i_dout(i_dout),
        .d_a(d_a), .d_strobe(d_strobe), .d_rw(d_rw), .d_size(d_size),
        .d_sel(d_sel), .d_din(d_din), .d_ready(d_ready), .d_dout(d_dout),
        .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write),
        .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
        .mem_ready(mem_ready), .mem_data(mem_data), .owner(owner)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic clearInputs();
        i_a = '0; i_strobe = 1'b0;
        d_a = '0; d_strobe = 1'b0; d_rw = 1'b0; d_size = '0; d_sel = '0; d_din = '0;
        mem_ready = 1'b0; mem_data = '0;
    endtask

    task automatic test_reset();
        clearInputs();
        resetn = 1'b1;
        #1 resetn = 1'b0;
        mem_ready = 1'b1;
        #1;
        nCompared++;
        if ({mem_access, owner, i_ready, d_ready} !== 5'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_ctrl: got %b, expected %b", {mem_access, owner, i_ready, d_ready}, 5'b0);
        end
        nCompared++;
        if ({mem_a, mem_write, mem_size, mem_sel, mem_st_data} !== 71'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_fields: got %h, expected 0", {mem_a, mem_write, mem_size, mem_sel, mem_st_data});
        end
        @(negedge clk);
        mem_ready = 1'b0;
        resetn = 1'b1;
    endtask

    task automatic test_lone_fetch();
        @(negedge clk);
        i_strobe = 1'b1; i_a = 32'hBFC00000;
        #1;
        nCompared++;
        if (mem_access !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL fetch_latency: got mem_access=%b, expected 0", mem_access);
        end
        @(negedge clk); #1;
        nCompared++;
        if ({mem_access, owner, mem_a, mem_size, mem_sel, mem_write, i_ready, d_ready} !==
            {1'b1, 2'b01, 32'hBFC00000, 2'b10, 4'hF, 1'b0, 1'b0, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL fetch_grant: got %h, expected %h",
                {mem_access, owner, mem_a, mem_size, mem_sel, mem_write, i_ready, d_ready},
                {1'b1, 2'b01, 32'hBFC00000, 2'b10, 4'hF, 1'b0, 1'b0, 1'b0});
        end
        @(negedge clk); #1;
        nCompared++;
        if ({mem_access, i_ready, d_ready} !== 3'b100) begin
            nMismatched++;
            $display("[TB] FAIL fetch_wait: got %b, expected 100", {mem_access, i_ready, d_ready});
        end
        @(negedge clk);
        mem_ready = 1'b1; mem_data = 32'h13579BDF; i_strobe = 1'b0;
        #1;
        nCompared++;
        if ({i_ready, d_ready, i_dout} !== {1'b1, 1'b0, 32'h13579BDF}) begin
            nMismatched++;
            $display("[TB] FAIL fetch_done: got %h, expected %h", {i_ready, d_ready, i_dout}, {1'b1, 1'b0, 32'h13579BDF});
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        nCompared++;
        if ({mem_access, owner, i_ready, d_ready} !== 5'b0) begin
            nMismatched++;
            $display("[TB] FAIL fetch_release: got %b, expected 00000", {mem_access, owner, i_ready, d_ready});
        end
    endtask

    task automatic test_lone_store();
        @(negedge clk);
        d_strobe = 1'b1; d_rw = 1'b1; d_a = 32'h80001004; d_sel = 4'b0011;
        d_din = 32'hDEADBEEF; d_size = 2'b10;
        @(negedge clk); #1;
        nCompared++;
        if ({mem_access, owner, mem_a, mem_write, mem_size, mem_sel, mem_st_data} !==
            {1'b1, 2'b10, 32'h80001004, 1'b1, 2'b10, 4'b0011, 32'hDEADBEEF}) begin
            nMismatched++;
            $display("[TB] FAIL store_grant: got %h, expected %h",
                {mem_access, owner, mem_a, mem_write, mem_size, mem_sel, mem_st_data},
                {1'b1, 2'b10, 32'h80001004, 1'b1, 2'b10, 4'b0011, 32'hDEADBEEF});
        end
        d_a = 32'h0; d_din = 32'h0; d_sel = 4'h0;
        @(negedge clk); #1;
        nCompared++;
        if ({mem_a, mem_sel, mem_st_data} !== {32'h80001004, 4'b0011, 32'hDEADBEEF}) begin
            nMismatched++;
            $display("[TB] FAIL store_hold: got %h, expected %h", {mem_a, mem_sel, mem_st_data},
                {32'h80001004, 4'b0011, 32'hDEADBEEF});
        end
        mem_ready = 1'b1; mem_data = 32'h0BADF00D; d_strobe = 1'b0;
        #1;
        nCompared++;
        if ({d_ready, i_ready, d_dout} !== {1'b1, 1'b0, 32'h0BADF00D}) begin
            nMismatched++;
            $display("[TB] FAIL store_done: got %h, expected %h", {d_ready, i_ready, d_dout}, {1'b1, 1'b0, 32'h0BADF00D});
        end
        @(negedge clk);
        clearInputs();
        #1;
        nCompared++;
        if ({mem_access, owner, d_ready} !== 4'b0) begin
            nMismatched++;
            $display("[TB] FAIL store_release: got %b, expected 0000", {mem_access, owner, d_ready});
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        i_strobe = 1'b1; i_a = 32'hBFC00010;
        d_strobe = 1'b1; d_a = 32'h80002000; d_rw = 1'b0; d_size = 2'b01; d_sel = 4'b0001;
        @(negedge clk); #1;
        nCompared++;
        if ({owner, mem_a, mem_size} !== {2'b10, 32'h80002000, 2'b01}) begin
            nMismatched++;
            $display("[TB] FAIL simul_first: got %h, expected %h", {owner, mem_a, mem_size}, {2'b10, 32'h80002000, 2'b01});
        end
        mem_ready = 1'b1; d_strobe = 1'b0;
        #1;
        nCompared++;
        if ({d_ready, i_ready} !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL simul_d_done: got %b, expected 10", {d_ready, i_ready});
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        nCompared++;
        if ({mem_access, owner, mem_a, mem_size, i_ready} !== {1'b1, 2'b01, 32'hBFC00010, 2'b10, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL simul_second: got %h, expected %h", {mem_access, owner, mem_a, mem_size, i_ready},
                {1'b1, 2'b01, 32'hBFC00010, 2'b10, 1'b0});
        end
        @(negedge clk);
        mem_ready = 1'b1; i_strobe = 1'b0;
        #1;
        nCompared++;
        if ({i_ready, d_ready} !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL simul_i_done: got %b, expected 10", {i_ready, d_ready});
        end
        @(negedge clk);
        clearInputs();
    endtask

    task automatic test_starvation();
        int expOwner[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        @(negedge clk);
        i_strobe = 1'b1; i_a = 32'hBFC00100;
        d_strobe = 1'b1; d_a = 32'h80003000;
        mem_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 9) begin
                i_strobe = 1'b0; d_strobe = 1'b0;
            end
            #1;
            nCompared++;
            if ({owner, i_ready, d_ready, mem_a} !==
                {2'(expOwner[k]), expOwner[k] == 1, expOwner[k] == 2,
                 (expOwner[k] == 1) ? 32'hBFC00100 : 32'h80003000}) begin
                nMismatched++;
                $display("[TB] FAIL starve_grant%0d: got owner=%b ready(i,d)=%b%b a=%h, expected owner=%0d",
                    k, owner, i_ready, d_ready, mem_a, expOwner[k]);
            end
        end
        @(negedge clk);
        clearInputs();
        #1;
        nCompared++;
        if ({mem_access, owner} !== 3'b0) begin
            nMismatched++;
            $display("[TB] FAIL starve_release: got %b, expected 000", {mem_access, owner});
        end
    endtask

    task automatic test_reset_mid_grant();
        @(negedge clk);
        i_strobe = 1'b1; i_a = 32'hBFC00200;
        d_strobe = 1'b1; d_a = 32'h80004000;
        @(negedge clk); #1;
        nCompared++;
        if (owner !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL rstmid_pre: got owner=%b, expected 10", owner);
        end
        #1 resetn = 1'b0;
        mem_ready = 1'b1;
        #1;
        nCompared++;
        if ({mem_access, owner, i_ready, d_ready, mem_a} !== 37'b0) begin
            nMismatched++;
            $display("[TB] FAIL rstmid_async: got %h, expected 0", {mem_access, owner, i_ready, d_ready, mem_a});
        end
        @(negedge clk);
        resetn = 1'b1; mem_ready = 1'b0; d_strobe = 1'b0;
        @(negedge clk); #1;
        nCompared++;
        if ({owner, mem_a} !== {2'b01, 32'hBFC00200}) begin
            nMismatched++;
            $display("[TB] FAIL rstmid_after: got %h, expected %h", {owner, mem_a}, {2'b01, 32'hBFC00200});
        end
        mem_ready = 1'b1; i_strobe = 1'b0;
        #1;
        nCompared++;
        if ({i_ready, d_ready} !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL rstmid_done: got %b, expected 10", {i_ready, d_ready});
        end
        @(negedge clk);
        clearInputs();
    endtask

    task automatic test_stray_ready();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_ready = 1'b1; mem_data = 32'hFFFF0000 + 32'(k);
            #1;
            nCompared++;
            if ({mem_access, owner, i_ready, d_ready} !== 5'b0) begin
                nMismatched++;
                $display("[TB] FAIL stray_ready%0d: got %b, expected 00000", k, {mem_access, owner, i_ready, d_ready});
            end
        end
        @(negedge clk);
        clearInputs();
    endtask

    // Randomized run against a reference model of the arbitration rules:
    // the port is reassigned whenever it is free (idle or completing); data
    // wins unless a fetch has waited through DMAX consecutive data grants.
    task automatic test_random();
        int          mOwner = 0;
        int          mRun   = 0;
        logic [31:0] eA = '0, eSt = '0;
        logic        eW = 1'b0;
        logic [1:0]  eSz = '0;
        logic [3:0]  eSel = '0;
        logic        eI, eD;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            i_strobe  = 1'($urandom_range(0, 1));
            d_strobe  = 1'($urandom_range(0, 1));
            i_a       = $urandom;
            d_a       = $urandom;
            d_rw      = 1'($urandom_range(0, 1));
            d_size    = 2'($urandom_range(0, 3));
            d_sel     = 4'($urandom_range(0, 15));
            d_din     = $urandom;
            mem_ready = ($urandom_range(0, 9) < 4);
            mem_data  = $urandom;
            #1;
            eI = (mOwner == 1) && mem_ready;
            eD = (mOwner == 2) && mem_ready;
            nCompared++;
            if ({mem_access, owner, i_ready, d_ready, i_dout, d_dout} !==
                {mOwner != 0, 2'(mOwner), eI, eD, mem_data, mem_data}) begin
                nMismatched++;
                $display("[TB] FAIL rand_ctrl cyc%0d: got acc=%b owner=%b rdy=%b%b, expected acc=%b owner=%0d rdy=%b%b",
                    cyc, mem_access, owner, i_ready, d_ready, mOwner != 0, mOwner, eI, eD);
            end
            if (mOwner != 0) begin
                nCompared++;
                if ({mem_a, mem_write, mem_size, mem_sel, mem_st_data} !== {eA, eW, eSz, eSel, eSt}) begin
                    nMismatched++;
                    $display("[TB] FAIL rand_fields cyc%0d: got %h, expected %h", cyc,
                        {mem_a, mem_write, mem_size, mem_sel, mem_st_data}, {eA, eW, eSz, eSel, eSt});
                end
            end
            if (mOwner == 0 || mem_ready) begin
                if (d_strobe && !(i_strobe && mRun >= DMAX)) begin
                    mOwner = 2;
                    eA = d_a; eW = d_rw; eSz = d_size; eSel = d_sel; eSt = d_din;
                    mRun = i_strobe ? ((mRun < DMAX) ? mRun + 1 : DMAX) : 0;
                end else if (i_strobe) begin
                    mOwner = 1;
                    eA = i_a; eW = 1'b0; eSz = 2'b10; eSel = 4'hF; eSt = '0;
                    mRun = 0;
                end else begin
                    mOwner = 0;
                end
            end
        end
        @(negedge clk);
        clearInputs();
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        test_reset();
        test_lone_fetch();
        test_lone_store();
        test_simultaneous();
        test_starvation();
        test_reset_mid_grant();
        test_stray_ready();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
Replaces the combinational cache_miss mux between i_cache and d_cache. It arbitrates both caches' miss/store requests onto the single memory port of axi_interface. It latches the winning request's fields and holds them stable until mem_ready. It routes the ready pulse and read data back to the owner only. Data side has priority, with a bounded-starvation guard for instruction fetch.

Parameters:
D_MAX_CONSEC, 4, maximum consecutive data grants while an instruction request waits; must be >= 1.
CNT_W, $clog2(D_MAX_CONSEC+1), width of the consecutive-grant counter (derived).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
i_a  in  32  i_cache memory address (m_a)
i_strobe  in  1  i_cache memory request (m_strobe)
i_ready  out  1  one-cycle completion pulse to i_cache
i_dout  out  32  read data to i_cache
d_a  in  32  d_cache memory address
d_strobe  in  1  d_cache memory request
d_rw  in  1  0 read, 1 write
d_size  in  2  d_cache access size
d_sel  in  4  byte strobes for store
d_din  in  32  store data from d_cache
d_ready  out  1  one-cycle completion pulse to d_cache
d_dout  out  32  read data to d_cache
mem_a  out  32  address to axi_interface
mem_access  out  1  request to axi_interface
mem_write  out  1  write flag
mem_size  out  2  size
mem_sel  out  4  byte strobes
mem_st_data  out  32  store data
mem_ready  in  1  axi_interface completion
mem_data  in  32  axi_interface read data
owner  out  2  00 none, 01 inst, 10 data (debug and perf)

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low.
- Reset values: state IDLE, owner 00, mem_access 0, mem_a/mem_size/mem_sel/mem_st_data/mem_write 0, d_cnt 0. i_ready and d_ready are 0 because they are gated by state.
- FSM states: IDLE, GNT_I, GNT_D (registered).
- IDLE:
  - If d_strobe and not (i_strobe and d_cnt==D_MAX_CONSEC): go to GNT_D.
  - Else if i_strobe: go to GNT_I.
  - Else stay in IDLE.
- Grant latching: on the entering edge, latch the request fields.
  - GNT_I: mem_a=i_a, mem_write=0, mem_size=2'b10, mem_sel=4'b1111, mem_st_data=0.
  - GNT_D: mem_a=d_a, mem_write=d_rw, mem_size=d_size, mem_sel=d_sel, mem_st_data=d_din.
- Grant timing: a request seen in cycle N gives mem_access=1 from cycle N+1.
- Held fields: latched fields do not change until the transaction completes, even if the requester changes its inputs.
- mem_access: equals (state != IDLE). It is combinational from state, so it stays high through the mem_ready cycle.
- Completion, cycle where mem_ready=1 in GNT_x:
  - x_ready=1 combinationally for exactly that cycle.
  - The other ready stays 0.
  - i_dout and d_dout both carry mem_data; only the owner's ready qualifies it.
- After completion, the next state is evaluated with the IDLE rules in the same edge. Back-to-back grants are allowed with no idle bubble; the fields of the new winner are latched on that edge.
- mem_ready while in IDLE is ignored; no ready is produced.
- Requester drops strobe while granted: the transaction still completes and the ready pulse is still produced. Caches hold strobe until ready by protocol.
- Starvation counter d_cnt, updated at each grant edge:
  - Data grant with i_strobe=1: d_cnt+1, saturating at D_MAX_CONSEC.
  - Data grant with i_strobe=0: d_cnt=0.
  - Instruction grant: d_cnt=0.
- Reset mid-transaction: immediate return to IDLE with all outputs at reset values. axi_interface shares resetn, so no orphaned beat is tracked.
- owner: mirrors state (GNT_I gives 01, GNT_D gives 10).

Decomposition:
- Shared package (cpu_defines):
  - arbiter state encoding IDLE/GNT_I/GNT_D;
  - owner codes;
  - SIZE_WORD=2'b10;
  - SEL_ALL=4'b1111.
- No sub-module: a single FSM plus field registers fits in one file. Top-level mycpu connects stallreq_from_if/mem to i_ready/d_ready unchanged.

Test Plan:
- Lone fetch: i_strobe=1, i_a=0xBFC00000, mem_ready on the 3rd granted cycle.
  - Expected: mem_access from cycle+1, mem_a=0xBFC00000, mem_size=10, mem_sel=F, mem_write=0.
  - Expected: i_ready pulses once, d_ready stays 0, owner=01 then 00.
- Lone store: d_rw=1, d_a=0x80001004, d_sel=4'b0011, d_din=0xDEADBEEF.
  - Expected: mem_* carry those values.
  - Expected: d_ready pulses on the mem_ready cycle.
  - Expected: mem_a stays 0x80001004 after d_a changes to 0 mid-grant.
- Simultaneous i_strobe and d_strobe from IDLE:
  - Expected: GNT_D first; on its mem_ready edge, GNT_I with no IDLE cycle in between.
  - Expected: i_ready arrives only after the i transaction's mem_ready.
- Starvation, D_MAX_CONSEC=4: d_strobe and i_strobe held high continuously, each transaction completed in 1 cycle.
  - Expected grant sequence: D,D,D,D,I,D,D,D,D,I.
  - Expected: d_cnt saturates at 4 and clears on the I grant.
- Reset mid-grant: assert resetn=0 during GNT_D.
  - Expected: mem_access=0 and owner=00 within the same cycle, asynchronously.
  - Expected: no ready pulse.
  - Expected: after release, a pending i_strobe is granted normally.
- Stray mem_ready=1 in IDLE:
  - Expected: no i_ready/d_ready, state unchanged.
